ecc_scrubber: RTL and testbench
===============================

// Module: ecc_scrubber
// PURPOSE
// - Background scrubber for a SECDED-protected SRAM bank, one address per trigger.
// - Consumes stored codewords through an internal ecc_decode.
// - On a single-bit error, writes back the corrected word, re-encoded by an internal ecc_encode.
// - Owns one memory port, arbitrated externally against core traffic via req/gnt.
// PARAMETERS
// - BankSize  : 256 : words in bank; addresses 0..BankSize-1.
// - DataWidth : 32  : payload bits per word.
// - CntWidth  : 16  : error counter width.
// - Derived:
//   - AddrWidth = $clog2(BankSize).
//   - CwWidth   = ecc_pkg::get_cw_width(DataWidth)+1.
// PORTS
// - clk_i            in  1         clock
// - rst_ni           in  1         async active-low reset
// - scrub_trigger_i  in  1         start one scrub step (sampled in IDLE only)
// - scrub_req_o      out 1         memory request
// - scrub_gnt_i      in  1         memory grant
// - scrub_we_o       out 1         1 = write-back, 0 = read
// - scrub_addr_o     out AddrWidth word address
// - scrub_wdata_o    out CwWidth   re-encoded corrected codeword
// - scrub_rdata_i    in  CwWidth   read codeword, valid the cycle after read gnt
// - busy_o           out 1         FSM not in IDLE
// - nb_corrected_o   out CntWidth  single errors fixed (saturating)
// - nb_uncorrect_o   out CntWidth  double errors seen (saturating)
// BEHAVIOUR
// - Reset (async, rst_ni=0), all outputs and state:
//   - state=IDLE, addr=0, req/we=0, wdata=0, busy=0, both counters=0.
// - States:
//   - IDLE: trigger=1 -> READ.
//   - READ: req=1, we=0, addr=cur.
//     - gnt=1 -> WAIT.
//   - WAIT: decode rdata.
//     - single_error -> WRITE; capture corrected word, encode it into wdata.
//     - double_error -> nb_uncorrect++; NEXT.
//     - otherwise (clean) -> NEXT.
//   - WRITE: req=1, we=1, addr=cur, wdata held.
//     - gnt=1 -> nb_corrected++; NEXT.
//   - NEXT (one cycle):
//     - addr = (addr==BankSize-1) ? 0 : addr+1.
//     - -> IDLE.
// - Handshake:
//   - req held with addr/we/wdata stable until gnt; no request withdrawal.
//   - gnt while req=0 is ignored.
// - Latency: clean scrub step = trigger -> READ (1) + gnt wait + WAIT (1) + NEXT (1).
//   - Minimum 4 cycles trigger-to-IDLE with gnt in the same cycle as req.
//   - Write-back step adds 1 + gnt wait.
// - Boundaries:
//   - trigger while busy: ignored.
//   - Counters stick at 2^CntWidth-1.
//   - Double error: never written back; the location is left as-is.
//   - Address wraps BankSize-1 -> 0.
//   - Reset mid-access: req drops immediately; the pending write is abandoned.
// - busy_o = (state != IDLE), combinational from state.
// CONFIGURATION
// - ECC_SCRUB_LOG_EN defined: adds outputs
//   - err_addr_o   [AddrWidth] : addr of the last double error; reset 0.
//   - err_valid_o  [1]         : set on any double error, cleared only by reset.
// - ECC_SCRUB_LOG_EN undefined: neither port exists; no extra flops.
// TESTING
// Common setup: DataWidth=32, BankSize=4, gnt tied high unless stated.
// 1. Clean memory, 4 triggers:
//    - reads at addr 0,1,2,3; no writes; counters 0.
//    - 5th trigger reads addr 0 (wrap).
// 2. Bit 5 of addr 2 codeword flipped, data 0xDEADBEEF; scrub addrs 0..2:
//    - one write at addr 2, wdata == encode(0xDEADBEEF).
//    - nb_corrected=1.
// 3. Bits 3 and 9 flipped at addr 1:
//    - no write; nb_uncorrect=1.
//    - with ECC_SCRUB_LOG_EN: err_addr=1, err_valid=1.
// 4. gnt held low 7 cycles during READ, then WRITE:
//    - req, addr, we, wdata stable every stalled cycle.
//    - triggers during stall ignored; addr advances by exactly 1.
// 5. rst_ni pulsed low during WRITE at addr 3:
//    - req=0 asynchronously, no write observed.
//    - addr=0, counters=0, busy=0 after release.
// 6. CntWidth=2, 5 single-error scrubs: nb_corrected saturates at 3.

Source files
------------

// File: rtl/ecc_scrubber.sv
// ecc_scrubber: background scrubber for a SECDED-protected SRAM bank.
// Each trigger scrubs one address: read the codeword, decode it, and on a
// single-bit error write back the corrected word re-encoded. Double errors
// are counted and left in place. The address advances and wraps per step.
//
// Codeword layout (CwWidth = Hamming width + 1):
//   bit 0              overall parity over the whole word (even)
//   bits 1..CwWidth-1  Hamming positions; parity at powers of two,
//                      data bits fill the remaining positions LSB first.
//
// Ports (top):
//   clk_i, rst_ni                  clock, async active-low reset
//   scrub_trigger_i                start one step (sampled in IDLE only)
//   scrub_req_o/scrub_gnt_i        memory request/grant handshake
//   scrub_we_o                     1 = write-back, 0 = read
//   scrub_addr_o                   word address
//   scrub_wdata_o                  re-encoded corrected codeword
//   scrub_rdata_i                  read codeword, valid the cycle after read gnt
//   busy_o                         FSM not in IDLE
//   nb_corrected_o/nb_uncorrect_o  saturating single/double error counters
// Optional build macro ECC_SCRUB_LOG_EN adds err_addr_o / err_valid_o,
// recording the address of the most recent double error.

package ecc_pkg;
  function automatic int unsigned get_par_bits(input int unsigned dw);
    int unsigned p;
    p = 0;
    for (int unsigned k = 0; k < 32; k++)
      if ((32'd1 << p) < dw + p + 1) p = p + 1;
    return p;
  endfunction

  function automatic int unsigned get_cw_width(input int unsigned dw);
    return dw + get_par_bits(dw);
  endfunction

  // Hamming positions covered by parity bit k (positions with bit k set).
  function automatic logic [63:0] pos_mask(input int unsigned k, input int unsigned cw_width);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 1; i < cw_width; i++)
      if (((i >> k) & 32'd1) != 0) m = m | (64'd1 << i);
    return m;
  endfunction
endpackage

module ecc_encode #(
  parameter  int unsigned DataWidth = 32,
  localparam int unsigned CwWidth   = ecc_pkg::get_cw_width(DataWidth) + 1
) (
  input  logic [DataWidth-1:0] data,
  output logic [CwWidth-1:0]   cw
);
  localparam int unsigned ParBits = ecc_pkg::get_par_bits(DataWidth);
  localparam logic [CwWidth-1:0] One = CwWidth'(1);

  always_comb begin
    logic [DataWidth-1:0] rest;
    cw   = '0;
    rest = data;
    for (int unsigned i = 1; i < CwWidth; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (rest[0]) cw = cw | (One << i);
        rest = rest >> 1;
      end
    end
    // Parity slots are still zero here, so the masked XOR is the parity value.
    for (int unsigned k = 0; k < ParBits; k++)
      if (^(cw & CwWidth'(ecc_pkg::pos_mask(k, CwWidth)))) cw = cw | (One << (32'd1 << k));
    if (^cw) cw = cw | One;
  end
endmodule

module ecc_decode #(
  parameter  int unsigned DataWidth = 32,
  localparam int unsigned CwWidth   = ecc_pkg::get_cw_width(DataWidth) + 1
) (
  input  logic [CwWidth-1:0]   cw,
  output logic [DataWidth-1:0] data,
  output logic                 single_err,
  output logic                 double_err
);
  localparam int unsigned ParBits = ecc_pkg::get_par_bits(DataWidth);
  localparam logic [CwWidth-1:0]   One  = CwWidth'(1);
  localparam logic [DataWidth-1:0] DOne = DataWidth'(1);

  logic [ParBits-1:0] syn;
  logic               overall;
  logic [CwWidth-1:0] fixed;

  always_comb begin
    logic [CwWidth-1:0] sh;
    int unsigned        j;
    syn = '0;
    for (int unsigned k = 0; k < ParBits; k++)
      if (^(cw & CwWidth'(ecc_pkg::pos_mask(k, CwWidth)))) syn = syn | (ParBits'(1) << k);
    overall = ^cw;
    // Odd overall parity with a syndrome inside the word is one flipped bit
    // (syndrome 0 means the overall parity bit itself).
    single_err = overall && (32'(syn) < CwWidth);
    double_err = (overall && !(32'(syn) < CwWidth)) || (!overall && (syn != '0));
    fixed = single_err ? (cw ^ (One << syn)) : cw;
    data = '0;
    sh   = '0;
    j    = 0;
    for (int unsigned i = 1; i < CwWidth; i++) begin
      if ((i & (i - 1)) != 0) begin
        sh = fixed >> i;
        if (sh[0]) data = data | (DOne << j);
        j = j + 1;
      end
    end
  end
endmodule

module ecc_scrubber #(
  parameter  int unsigned BankSize  = 256,
  parameter  int unsigned DataWidth = 32,
  parameter  int unsigned CntWidth  = 16,
  localparam int unsigned AddrWidth = $clog2(BankSize),
  localparam int unsigned CwWidth   = ecc_pkg::get_cw_width(DataWidth) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 scrub_trigger_i,
  output logic                 scrub_req_o,
  input  logic                 scrub_gnt_i,
  output logic                 scrub_we_o,
  output logic [AddrWidth-1:0] scrub_addr_o,
  output logic [CwWidth-1:0]   scrub_wdata_o,
  input  logic [CwWidth-1:0]   scrub_rdata_i,
  output logic                 busy_o,
  output logic [CntWidth-1:0]  nb_corrected_o,
  output logic [CntWidth-1:0]  nb_uncorrect_o
`ifdef ECC_SCRUB_LOG_EN
  ,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 err_valid_o
`endif
);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(BankSize - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, NEXT} state_t;

  state_t                 state, state_nxt;
  logic [AddrWidth-1:0]   addr;
  logic [CwWidth-1:0]     wdata;
  logic [CwWidth-1:0]     enc_cw;
  logic [DataWidth-1:0]   dec_data;
  logic                   single_err, double_err;

  ecc_decode #(.DataWidth(DataWidth)) u_dec (
    .cw         (scrub_rdata_i),
    .data       (dec_data),
    .single_err (single_err),
    .double_err (double_err)
  );

  ecc_encode #(.DataWidth(DataWidth)) u_enc (
    .data (dec_data),
    .cw   (enc_cw)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    scrub_req_o = 1'b0;
    scrub_we_o  = 1'b0;
    case (state)
      IDLE:  if (scrub_trigger_i) state_nxt = READ;
      READ: begin
        scrub_req_o = 1'b1;
        if (scrub_gnt_i) state_nxt = WAIT;
      end
      WAIT:  state_nxt = single_err ? WRITE : NEXT;
      WRITE: begin
        scrub_req_o = 1'b1;
        scrub_we_o  = 1'b1;
        if (scrub_gnt_i) state_nxt = NEXT;
      end
      NEXT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr           <= '0;
      wdata          <= '0;
      nb_corrected_o <= '0;
      nb_uncorrect_o <= '0;
`ifdef ECC_SCRUB_LOG_EN
      err_addr_o     <= '0;
      err_valid_o    <= 1'b0;
`endif
    end else begin
      if (state == WAIT && single_err) wdata <= enc_cw;
      if (state == WAIT && double_err) begin
        if (nb_uncorrect_o != '1) nb_uncorrect_o <= nb_uncorrect_o + 1'b1;
`ifdef ECC_SCRUB_LOG_EN
        err_addr_o  <= addr;
        err_valid_o <= 1'b1;
`endif
      end
      if (state == WRITE && scrub_gnt_i && nb_corrected_o != '1)
        nb_corrected_o <= nb_corrected_o + 1'b1;
      if (state == NEXT) addr <= (addr == LastAddr) ? '0 : addr + 1'b1;
    end
  end

  assign busy_o        = (state != IDLE);
  assign scrub_addr_o  = addr;
  assign scrub_wdata_o = wdata;
endmodule

// File: tb/tb_ecc_scrubber.sv
module tb_ecc_scrubber;
  logic        clk;
  logic        rst_n, trig, gnt;
  logic        req, we, busy;
  logic [1:0]  addr;
  logic [38:0] wdata;
  logic [38:0] rdata = '0;
  logic [15:0] nb_corr, nb_unc;
  logic        s_req, s_we, s_busy;
  logic [1:0]  s_addr;
  logic [38:0] s_wdata;
  logic [1:0]  s_corr, s_unc;
`ifdef ECC_SCRUB_LOG_EN
  logic [1:0]  err_addr, s_err_addr;
  logic        err_valid, s_err_valid;
`endif

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ecc_scrubber #(.BankSize(4), .DataWidth(32), .CntWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .scrub_trigger_i(trig), .scrub_req_o(req),
    .scrub_gnt_i(gnt), .scrub_we_o(we), .scrub_addr_o(addr), .scrub_wdata_o(wdata),
    .scrub_rdata_i(rdata), .busy_o(busy), .nb_corrected_o(nb_corr), .nb_uncorrect_o(nb_unc)
`ifdef ECC_SCRUB_LOG_EN
    , .err_addr_o(err_addr), .err_valid_o(err_valid)
`endif
  );

  // Same stimulus, 2-bit counters: exercises saturation.
  ecc_scrubber #(.BankSize(4), .DataWidth(32), .CntWidth(2)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .scrub_trigger_i(trig), .scrub_req_o(s_req),
    .scrub_gnt_i(gnt), .scrub_we_o(s_we), .scrub_addr_o(s_addr), .scrub_wdata_o(s_wdata),
    .scrub_rdata_i(rdata), .busy_o(s_busy), .nb_corrected_o(s_corr), .nb_uncorrect_o(s_unc)
`ifdef ECC_SCRUB_LOG_EN
    , .err_addr_o(s_err_addr), .err_valid_o(s_err_valid)
`endif
  );

  // Memory model shared by both instances (driven from dut's request).
  logic [38:0] mem [4];
  logic        load_en = 1'b0;
  logic [1:0]  load_addr = '0;
  logic [38:0] load_data = '0;
  int          wr_count = 0;
  int          rd_count = 0;
  logic [1:0]  last_wr_addr = '0, last_rd_addr = '0;
  logic [38:0] last_wr_data = '0;

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (req && gnt) begin
      if (we) begin
        mem[addr]    <= wdata;
        wr_count     <= wr_count + 1;
        last_wr_addr <= addr;
        last_wr_data <= wdata;
      end else begin
        rdata        <= mem[addr];
        rd_count     <= rd_count + 1;
        last_rd_addr <= addr;
      end
    end
  end

  // Reference encoder: parity bits are the XOR of the positions of set data bits.
  function automatic logic [38:0] ref_enc(input logic [31:0] d);
    logic [38:0] cw;
    logic [31:0] dd;
    int unsigned pos, syn;
    cw = '0; dd = d; pos = 1; syn = 0;
    for (int unsigned j = 0; j < 32; j++) begin
      while ((pos & (pos - 1)) == 0) pos++;
      if (dd[0]) begin
        cw  = cw | (39'd1 << pos);
        syn = syn ^ pos;
      end
      dd  = dd >> 1;
      pos = pos + 1;
    end
    for (int unsigned k = 0; k < 6; k++)
      if (((syn >> k) & 32'd1) != 0) cw = cw | (39'd1 << (32'd1 << k));
    if (^cw) cw = cw | 39'd1;
    return cw;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic load(input int unsigned a, input logic [38:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = 2'(a); load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; trig = 1'b0; gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic scrub(output int unsigned lat);
    int unsigned n;
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    n = 1;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    chk("step_done", 64'(busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat, n;
    int wb, rb;
    rst_n = 1'b0; trig = 1'b0; gnt = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_req",   64'(req),     64'd0);
    chk("rst_we",    64'(we),      64'd0);
    chk("rst_addr",  64'(addr),    64'd0);
    chk("rst_wdata", 64'(wdata),   64'd0);
    chk("rst_busy",  64'(busy),    64'd0);
    chk("rst_corr",  64'(nb_corr), 64'd0);
    chk("rst_unc",   64'(nb_unc),  64'd0);
`ifdef ECC_SCRUB_LOG_EN
    chk("rst_errv",  64'(err_valid), 64'd0);
    chk("rst_erra",  64'(err_addr),  64'd0);
`endif
    rst_n = 1'b1;

    // 1: clean memory, sequential reads and wrap
    load(0, ref_enc(32'h0000_0000));
    load(1, ref_enc(32'h1234_5678));
    load(2, ref_enc(32'hDEAD_BEEF));
    load(3, ref_enc(32'hFFFF_FFFF));
    wb = wr_count;
    for (int unsigned i = 0; i < 4; i++) begin
      scrub(lat);
      chk("t1_rd_addr", 64'(last_rd_addr), 64'(i));
      chk("t1_lat",     64'(lat),          64'd4);
    end
    chk("t1_writes", 64'(wr_count - wb), 64'd0);
    chk("t1_corr",   64'(nb_corr),       64'd0);
    chk("t1_unc",    64'(nb_unc),        64'd0);
    chk("t1_wrap",   64'(addr),          64'd0);
    scrub(lat);
    chk("t1_rd5_addr", 64'(last_rd_addr), 64'd0);
    chk("t1_addr5",    64'(addr),         64'd1);

    // 2: single error (bit 5) at addr 2
    do_reset();
    load(2, ref_enc(32'hDEAD_BEEF) ^ (39'd1 << 5));
    wb = wr_count;
    scrub(lat); scrub(lat);
    chk("t2_lat_clean", 64'(lat), 64'd4);
    scrub(lat);
    chk("t2_lat_wb",    64'(lat),            64'd5);
    chk("t2_writes",    64'(wr_count - wb),  64'd1);
    chk("t2_wr_addr",   64'(last_wr_addr),   64'd2);
    chk("t2_wr_data",   64'(last_wr_data),   64'(ref_enc(32'hDEAD_BEEF)));
    chk("t2_mem2",      64'(mem[2]),         64'(ref_enc(32'hDEAD_BEEF)));
    chk("t2_corr",      64'(nb_corr),        64'd1);
    chk("t2_unc",       64'(nb_unc),         64'd0);

    // 3: double error (bits 3, 9) at addr 1
    do_reset();
    load(1, ref_enc(32'h1234_5678) ^ (39'd1 << 3) ^ (39'd1 << 9));
    wb = wr_count;
    scrub(lat); scrub(lat);
    chk("t3_lat",    64'(lat),           64'd4);
    chk("t3_writes", 64'(wr_count - wb), 64'd0);
    chk("t3_unc",    64'(nb_unc),        64'd1);
    chk("t3_corr",   64'(nb_corr),       64'd0);
    chk("t3_mem1",   64'(mem[1]), 64'(ref_enc(32'h1234_5678) ^ (39'd1 << 3) ^ (39'd1 << 9)));
`ifdef ECC_SCRUB_LOG_EN
    chk("t3_erra",   64'(err_addr),  64'd1);
    chk("t3_errv",   64'(err_valid), 64'd1);
`endif

    // 4: grant stalls in READ and WRITE; triggers while busy ignored
    do_reset();
    load(0, ref_enc(32'hA5A5_A5A5) ^ (39'd1 << 20));
    wb = wr_count; rb = rd_count;
    @(negedge clk); gnt = 1'b0; trig = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t4_rd_req",   64'(req),   64'd1);
      chk("t4_rd_we",    64'(we),    64'd0);
      chk("t4_rd_addr",  64'(addr),  64'd0);
      chk("t4_rd_wdata", 64'(wdata), 64'd0);
    end
    gnt = 1'b1;
    @(negedge clk); gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_wr_req",   64'(req),   64'd1);
      chk("t4_wr_we",    64'(we),    64'd1);
      chk("t4_wr_addr",  64'(addr),  64'd0);
      chk("t4_wr_wdata", 64'(wdata), 64'(ref_enc(32'hA5A5_A5A5)));
    end
    trig = 1'b0; gnt = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_idle",   64'(busy),           64'd0);
    chk("t4_addr",   64'(addr),           64'd1);
    chk("t4_reads",  64'(rd_count - rb),  64'd1);
    chk("t4_writes", 64'(wr_count - wb),  64'd1);
    chk("t4_wrdata", 64'(last_wr_data),   64'(ref_enc(32'hA5A5_A5A5)));
    chk("t4_corr",   64'(nb_corr),        64'd1);

    // 5: reset asserted during WRITE at addr 3
    do_reset();
    load(1, ref_enc(32'h1234_5678) ^ (39'd1 << 3) ^ (39'd1 << 9));
    load(2, ref_enc(32'hDEAD_BEEF));
    load(3, ref_enc(32'h0F0F_0F0F) ^ 39'd1);
    scrub(lat); scrub(lat); scrub(lat);
    chk("t5_unc_pre", 64'(nb_unc), 64'd1);
    wb = wr_count;
    @(negedge clk); gnt = 1'b0; trig = 1'b1;
    @(negedge clk); trig = 1'b0; gnt = 1'b1;
    @(negedge clk); gnt = 1'b0;
    @(negedge clk);
    chk("t5_wr_req",   64'(req),   64'd1);
    chk("t5_wr_we",    64'(we),    64'd1);
    chk("t5_wr_addr",  64'(addr),  64'd3);
    chk("t5_wr_wdata", 64'(wdata), 64'(ref_enc(32'h0F0F_0F0F)));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_req",  64'(req),    64'd0);
    chk("t5_async_busy", 64'(busy),   64'd0);
    chk("t5_async_unc",  64'(nb_unc), 64'd0);
    @(negedge clk); gnt = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("t5_writes", 64'(wr_count - wb), 64'd0);
    chk("t5_mem3",   64'(mem[3]),  64'(ref_enc(32'h0F0F_0F0F) ^ 39'd1));
    chk("t5_addr",   64'(addr),    64'd0);
    chk("t5_corr",   64'(nb_corr), 64'd0);
    chk("t5_unc",    64'(nb_unc),  64'd0);
    chk("t5_busy",   64'(busy),    64'd0);
    chk("t5_wdata",  64'(wdata),   64'd0);
`ifdef ECC_SCRUB_LOG_EN
    chk("t5_errv",   64'(err_valid), 64'd0);
`endif

    // 6: counter saturation on the 2-bit instance
    do_reset();
    load(0, ref_enc(32'h1111_1111) ^ (39'd1 << 10));
    load(1, ref_enc(32'h2222_2222) ^ (39'd1 << 11));
    load(2, ref_enc(32'h3333_3333) ^ (39'd1 << 12));
    load(3, ref_enc(32'h4444_4444) ^ (39'd1 << 13));
    scrub(lat); scrub(lat);
    chk("t6_sat2", 64'(s_corr), 64'd2);
    scrub(lat);
    chk("t6_sat3", 64'(s_corr), 64'd3);
    scrub(lat);
    chk("t6_sat4", 64'(s_corr),  64'd3);
    chk("t6_cnt4", 64'(nb_corr), 64'd4);
    load(0, ref_enc(32'h5555_5555) ^ (39'd1 << 30));
    scrub(lat);
    chk("t6_lat5",  64'(lat),     64'd5);
    chk("t6_sat5",  64'(s_corr),  64'd3);
    chk("t6_cnt5",  64'(nb_corr), 64'd5);
    chk("t6_sunc",  64'(s_unc),   64'd0);
    chk("t6_saddr", 64'(s_addr),  64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
